// File: rtl/key_irq_sequencer_if.sv
// key_irq_sequencer_if: PIO Avalon-MM bus and event stream bundle for key_irq_sequencer.
// Revision: 1.0
`default_nettype none

interface key_irq_sequencer_if #(
  parameter int EVT_W = 2
) ();
  logic [1:0]       pio_address;
  logic             pio_chipselect;
  logic             pio_write_n;
  logic [31:0]      pio_writedata;
  logic [31:0]      pio_readdata;
  logic             pio_irq;
  logic             evt_valid;
  logic [EVT_W-1:0] evt_data;
  logic             evt_ready;

  modport master (
    output pio_address, pio_chipselect, pio_write_n, pio_writedata,
    output evt_valid, evt_data,
    input  pio_readdata, pio_irq, evt_ready
  );

  modport slave (
    input  pio_address, pio_chipselect, pio_write_n, pio_writedata,
    input  evt_valid, evt_data,
    output pio_readdata, pio_irq, evt_ready
  );
endinterface

`default_nettype wire

// File: rtl/key_irq_sequencer.sv
// key_irq_sequencer: services KEY PIO interrupts and queues captured edges in a FWFT FIFO.
// Optional macro KEY_IRQ_SEQ_TIMESTAMP_EN prepends a TS_WIDTH timestamp to each event. Revision: 1.0
`default_nettype none

module key_irq_sequencer #(
  parameter logic [1:0] KEY_MASK   = 2'b11,
  parameter int         FIFO_DEPTH = 8,
  parameter int         TS_WIDTH   = 16
) (
  input  wire                  clk,
  input  wire                  reset_n,
  input  wire                  i_enable,
  input  wire                  i_ovf_clr,
  output logic                 o_overflow,
  output logic                 o_busy,
  key_irq_sequencer_if.master  bus
);

  localparam int AW = $clog2(FIFO_DEPTH);
`ifdef KEY_IRQ_SEQ_TIMESTAMP_EN
  localparam int EW = TS_WIDTH + 2;
`else
  localparam int EW = 2;
`endif

  localparam logic [2:0] c_INIT = 3'd0;
  localparam logic [2:0] c_IDLE = 3'd1;
  localparam logic [2:0] c_RD   = 3'd2;
  localparam logic [2:0] c_WAIT = 3'd3;
  localparam logic [2:0] c_CLR  = 3'd4;
  localparam logic [2:0] c_PUSH = 3'd5;

  logic [2:0]  r_state, w_state_nxt;
  logic        r_irq;
  logic [1:0]  r_cap, w_cap;
  logic [1:0]  r_addr, w_addr;
  logic        r_cs, w_cs;
  logic        r_wn, w_wn;
  logic [31:0] r_wd, w_wd;
  logic        r_busy;
  logic [29:0] w_unused_rd;

  assign w_cap       = bus.pio_readdata[1:0] & KEY_MASK;
  assign w_unused_rd = bus.pio_readdata[31:2];

  // Bus fields are decided here and registered, so each bus cycle lines up with the next state.
  always_comb begin
    w_state_nxt = r_state;
    w_addr      = 2'd0;
    w_cs        = 1'b0;
    w_wn        = 1'b1;
    w_wd        = 32'd0;
    case (r_state)
      c_INIT: begin
        w_addr      = 2'd2;
        w_cs        = 1'b1;
        w_wn        = 1'b0;
        w_wd        = {30'd0, KEY_MASK};
        w_state_nxt = c_IDLE;
      end
      c_IDLE: begin
        if (r_irq && i_enable) begin
          w_addr      = 2'd3;
          w_cs        = 1'b1;
          w_state_nxt = c_RD;
        end
      end
      c_RD: w_state_nxt = c_WAIT;
      c_WAIT: begin
        if (w_cap == 2'b00) begin
          w_state_nxt = c_IDLE;
        end else begin
          w_addr      = 2'd3;
          w_cs        = 1'b1;
          w_wn        = 1'b0;
          w_wd        = {30'd0, w_cap};
          w_state_nxt = c_CLR;
        end
      end
      c_CLR:   w_state_nxt = c_PUSH;
      c_PUSH:  w_state_nxt = c_IDLE;
      default: w_state_nxt = c_INIT;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= c_INIT;
      r_irq   <= 1'b0;
      r_cap   <= 2'b00;
      r_addr  <= 2'd0;
      r_cs    <= 1'b0;
      r_wn    <= 1'b1;
      r_wd    <= 32'd0;
      r_busy  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_irq   <= bus.pio_irq;
      r_addr  <= w_addr;
      r_cs    <= w_cs;
      r_wn    <= w_wn;
      r_wd    <= w_wd;
      r_busy  <= (w_state_nxt != c_IDLE);
      if (r_state == c_WAIT) begin
        r_cap <= w_cap;
      end
    end
  end

  logic [EW-1:0] w_evt;

`ifdef KEY_IRQ_SEQ_TIMESTAMP_EN
  logic [TS_WIDTH-1:0] r_ts, r_ts_cap;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_ts     <= '0;
      r_ts_cap <= '0;
    end else begin
      r_ts <= r_ts + 1'b1;
      if (r_state == c_WAIT) begin
        r_ts_cap <= r_ts;
      end
    end
  end

  assign w_evt = {r_ts_cap, r_cap};
`else
  assign w_evt = r_cap;
`endif

  logic [EW-1:0] r_mem [FIFO_DEPTH];
  logic [AW:0]   r_wr, r_rd, w_wr_nxt, w_rd_nxt;
  logic          w_full, w_push, w_wr_en, w_pop, w_empty_nxt;
  logic          r_valid, r_ovf;
  logic [EW-1:0] r_head, w_head_nxt;

  assign w_full   = (r_wr[AW] != r_rd[AW]) && (r_wr[AW-1:0] == r_rd[AW-1:0]);
  assign w_push   = (r_state == c_PUSH);
  assign w_wr_en  = w_push && !w_full;
  assign w_pop    = r_valid && bus.evt_ready;
  assign w_wr_nxt = w_wr_en ? r_wr + 1'b1 : r_wr;
  assign w_rd_nxt = w_pop   ? r_rd + 1'b1 : r_rd;
  assign w_empty_nxt = (w_wr_nxt == w_rd_nxt);

  // The head register is preloaded so the event is visible the cycle it lands, bypassing memory
  // when the slot being written is about to become the head.
  always_comb begin
    w_head_nxt = '0;
    if (!w_empty_nxt) begin
      if (w_wr_en && (r_wr[AW-1:0] == w_rd_nxt[AW-1:0])) begin
        w_head_nxt = w_evt;
      end else begin
        w_head_nxt = r_mem[w_rd_nxt[AW-1:0]];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_wr_en) begin
      r_mem[r_wr[AW-1:0]] <= w_evt;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_wr    <= '0;
      r_rd    <= '0;
      r_valid <= 1'b0;
      r_head  <= '0;
      r_ovf   <= 1'b0;
    end else begin
      r_wr    <= w_wr_nxt;
      r_rd    <= w_rd_nxt;
      r_valid <= !w_empty_nxt;
      r_head  <= w_head_nxt;
      if (w_push && w_full) begin
        r_ovf <= 1'b1;
      end else if (i_ovf_clr) begin
        r_ovf <= 1'b0;
      end
    end
  end

  assign bus.pio_address    = r_addr;
  assign bus.pio_chipselect = r_cs;
  assign bus.pio_write_n    = r_wn;
  assign bus.pio_writedata  = r_wd;
  assign bus.evt_valid      = r_valid;
  assign bus.evt_data       = r_head;
  assign o_overflow         = r_ovf;
  assign o_busy             = r_busy;

endmodule

`default_nettype wire

// File: doc/key_irq_sequencer.md
# key_irq_sequencer

Hardware service engine for the two-bit KEY PIO slave. It replaces the Nios interrupt handler for the keys. After reset it programs the PIO interrupt mask. On each PIO `irq` it reads the edge-capture register and clears the bits it read. Each non-zero capture goes into a small first-word-fall-through event FIFO that downstream logic drains with a valid/ready handshake. It sits between the PIO's Avalon-MM slave port and the PWM/DAC control logic.

## Interface
Parameters:
- `KEY_MASK`, default 2'b11: interrupt mask written to PIO address 2 at init; also ANDed with every captured value.
- `FIFO_DEPTH`, default 8: event FIFO depth; must be a power of two, at least 2.
- `TS_WIDTH`, default 16: timestamp counter width; used only with `KEY_IRQ_SEQ_TIMESTAMP_EN`.

Ports:
- `clk` in 1: clock.
- `reset_n` in 1: reset, asynchronous, active-low.
- `enable` in 1: allows new service sequences to start.
- `pio_irq` in 1: PIO interrupt.
- `pio_address` out 2: PIO register select.
- `pio_chipselect` out 1: PIO select.
- `pio_write_n` out 1: PIO write strobe, active-low.
- `pio_writedata` out 32: PIO write data.
- `pio_readdata` in 32: PIO read data; registered, 1-cycle fixed latency, no waitrequest.
- `evt_valid` out 1: FIFO not empty.
- `evt_data` out EW: head event. EW = 2, or TS_WIDTH+2 with the timestamp option.
- `evt_ready` in 1: consumer accepts the head event.
- `overflow` out 1: sticky flag, set when an event was dropped.
- `ovf_clr` in 1: clears `overflow`.
- `busy` out 1: FSM is not in IDLE.

## Operation
FSM states: INIT, IDLE, RD, WAIT, CLR, PUSH.
- **INIT** (first state after reset):
  - Drive a write: address 2, chipselect 1, write_n 0, writedata = {30'b0, KEY_MASK}.
  - Next state: IDLE.
- **IDLE:**
  - If `pio_irq` && `enable`, go to RD.
  - Bus idle: chipselect 0, write_n 1, address 0, writedata 0.
- **RD:**
  - Drive address 3, chipselect 1, write_n 1.
  - Next state: WAIT.
- **WAIT:**
  - Latch cap = `pio_readdata[1:0]` & KEY_MASK.
  - Latch the timestamp if configured.
  - If cap == 0 (spurious interrupt), go to IDLE without writing or pushing.
  - Otherwise go to CLR.
- **CLR:**
  - Write cap to address 3. This is write-1-to-clear, so only the serviced bits are cleared; edges arriving meanwhile remain pending.
  - Next state: PUSH.
- **PUSH:**
  - Write the event into the FIFO.
  - Next state: IDLE.
- Deasserting `enable` never aborts a sequence in progress; it only blocks the IDLE→RD transition.
- FIFO:
  - Pop on `evt_valid && evt_ready`.
  - Pointers carry one extra bit to distinguish full from empty.
  - Full is evaluated before a same-cycle pop. A PUSH while full drops the event and sets `overflow`, even if a pop happens in that cycle.
  - FIFO contents are unchanged by `overflow` or `ovf_clr`.
- `overflow`:
  - Set has priority over `ovf_clr` in the same cycle.
  - Otherwise `ovf_clr` clears it on the next edge.
- Reset mid-operation:
  - All state clears immediately, the FIFO empties and INIT is reissued.
  - Pending PIO edge-capture bits are left to the PIO's own reset.

## Timing
- Reset values:
  - `pio_address` 0, `pio_chipselect` 0, `pio_write_n` 1, `pio_writedata` 0.
  - `evt_valid` 0, `evt_data` 0, `overflow` 0, `busy` 0.
- All outputs are registered.
- The INIT write is on the bus in the first cycle after `reset_n` deasserts.
- With `pio_irq` sampled high at edge k, the sequence runs:
  - Read on the bus in cycle k+1.
  - `pio_readdata` captured at edge k+3.
  - Clear-write on the bus in cycle k+3.
  - FIFO write at edge k+5.
  - `evt_valid` high from k+5 if the FIFO was empty.
- `pio_irq` falls one cycle after the clear-write; the FSM re-enters IDLE with irq already low unless a new edge occurred.
- Minimum spacing between service sequences is 5 cycles.
- FIFO fall-through latency is 0: `evt_data` is valid whenever `evt_valid` is high.
- `evt_data` is held stable until popped.

## Configuration
- Macro `KEY_IRQ_SEQ_TIMESTAMP_EN`.
- Defined:
  - A free-running TS_WIDTH counter, reset to 0, wraps modulo 2^TS_WIDTH.
  - It is sampled in WAIT.
  - `evt_data` = {timestamp, cap}, width TS_WIDTH+2.
- Undefined:
  - No counter is built.
  - `evt_data` = cap, width 2.

## Test plan
- **Reset/init:** release `reset_n` → one write cycle, address 2, writedata 0x3; then bus idle, `busy` 0.
- **Single key:** PIO model sets capture 2'b01 and irq → read of address 3, write 0x1 to address 3, then `evt_valid` 1 with `evt_data[1:0]` = 2'b01. Check cycle offsets k+1, k+3, k+5.
- **Spurious irq:** irq with capture 0 → read occurs, no write, no push, FSM back in IDLE after WAIT.
- **Overflow:** hold `evt_ready` 0 and generate 9 events with FIFO_DEPTH 8 → 8 stored, `overflow` 1. Pulse `ovf_clr` → `overflow` 0. Drain → 8 events in order.
- **Enable gating and reset mid-sequence:** `enable` 0 with irq high → no bus activity. Assert `reset_n` low during CLR → outputs at reset values, FIFO empty, INIT repeated after release.
- **Timestamp** (macro defined): two events 100 cycles apart → timestamp difference 100, including across a counter wrap.
